mc_signal_generator: RTL
========================

// Module: mc_signal_generator
// PURPOSE
//  Transmit side of the motor-controller (MC) command path: converts the 5-bit MC code {power[4:2], dir[1:0]}
//  into the RC-style pulse frame sent to the motor controller, one pulse per 11 ms frame.
//  Reports the code actually being transmitted on CURRENT_MC, which is fed back to acceleration modulation.
//  Dir encoding: 2'b01 neutral, 2'b10 forward, 2'b00 reverse, 2'b11 invalid (sent as neutral). Power 0..7 = 12.5%..100%.
// PARAMETERS
//  FRAME_CYCLES    1100000  clocks per frame (11 ms at 100 MHz)
//  NEUTRAL_CYCLES  150000   neutral pulse width (1.5 ms)
//  STEP_CYCLES     6250     pulse-width change per power step (62.5 us)
//  FAILSAFE_FRAMES 8        consecutive frames with no CODE_VALID before forcing neutral (MC_FAILSAFE_EN only)
//  Legal only if NEUTRAL_CYCLES > 8*STEP_CYCLES and NEUTRAL_CYCLES + 8*STEP_CYCLES < FRAME_CYCLES.
// PORTS
//  CLK          in   1   system clock (100 MHz)
//  RST          in   1   synchronous reset, active-high
//  MC_CODE      in   5   requested code {power, dir}
//  CODE_VALID   in   1   single-cycle strobe: upstream refreshed MC_CODE (used only with MC_FAILSAFE_EN)
//  MC_PWM       out  1   pulse output to motor controller
//  CURRENT_MC   out  5   canonical code latched for the frame in progress
//  FRAME_START  out  1   1-cycle pulse on the first cycle of every frame
//  FAILSAFE     out  1   high while the current frame was forced to neutral by the watchdog
// BEHAVIOUR
//  Reset (RST=1 at an edge): frame counter=0, CURRENT_MC=5'b00001, width register=NEUTRAL_CYCLES,
//   MC_PWM=0, FRAME_START=0, FAILSAFE=0, watchdog miss count=0, seen flag=0. Reset mid-pulse drops MC_PWM on that edge.
//  Frame counter cnt runs 0..FRAME_CYCLES-1 and wraps. On the first edge after RST is released, the first frame begins (cnt=0).
//  Frame boundary = the edge at which cnt becomes 0 (including the first edge after reset). At that edge:
//   - MC_CODE is sampled, canonicalised, and loaded into CURRENT_MC. Latency: a code change applies at the next boundary only.
//     Mid-frame MC_CODE changes are ignored.
//   - Width register W is loaded: neutral -> NEUTRAL_CYCLES; forward -> NEUTRAL_CYCLES + (p+1)*STEP_CYCLES;
//     reverse -> NEUTRAL_CYCLES - (p+1)*STEP_CYCLES. Arithmetic is unsigned, with a counter wide enough for FRAME_CYCLES
//     (21 bits at default). No overflow is possible under the legal-parameter rule.
//   - FRAME_START=1 for exactly this cycle.
//  Canonicalisation: dir 01 or 11 -> 5'b00001 (power forced 0). Forward and reverse pass through unchanged.
//  MC_PWM=1 for cnt in [0, W-1], 0 for cnt in [W, FRAME_CYCLES-1]. MC_PWM is registered and glitch-free.
//  State machine: PULSE (MC_PWM high) -> GAP when cnt reaches W-1 -> PULSE at the boundary. RST forces GAP with cnt held at 0.
//  At defaults: fwd p7 = 200000 cycles, neutral = 150000, rev p7 = 100000, rev p0 = 143750.
// CONFIGURATION
//  MC_FAILSAFE_EN defined:
//   - seen flag sets on any cycle with CODE_VALID=1. A CODE_VALID on the boundary edge itself counts toward that boundary.
//     seen clears at every boundary.
//   - At each boundary: if seen is set, miss=0; otherwise miss=miss+1 (saturating).
//   - If the updated miss >= FAILSAFE_FRAMES, the boundary latches 5'b00001 with W=NEUTRAL_CYCLES and sets FAILSAFE=1.
//     Otherwise it latches normally and sets FAILSAFE=0.
//   - Recovery is immediate: the first boundary with seen set transmits MC_CODE.
//  MC_FAILSAFE_EN undefined: CODE_VALID is ignored, FAILSAFE is tied 0, no watchdog logic is built.
// TESTING
//  1. Hold RST 3 cycles, then release -> outputs hold reset values during reset.
//     FRAME_START pulses on the first edge after release; CURRENT_MC=00001; MC_PWM high 150000 cycles.
//  2. MC_CODE=5'b11110 (fwd p7) before a boundary -> MC_PWM high 200000 cycles, low 900000; CURRENT_MC=11110; period 1100000.
//  3. MC_CODE=5'b00000 (rev p0) -> pulse 143750 cycles. Change to 5'b11100 at cnt=500 ->
//     current frame unchanged, next frame pulse 100000.
//  4. MC_CODE=5'b10111 (invalid dir) -> CURRENT_MC=00001, pulse 150000.
//  5. Assert RST at cnt=1000 of a fwd p7 frame -> MC_PWM=0 and CURRENT_MC=00001 the next cycle.
//     After release, the frame restarts at cnt=0 with a fresh MC_CODE sample.
//  6. (MC_FAILSAFE_EN) MC_CODE=11110, CODE_VALID once per frame, then stop ->
//     8th boundary without a strobe gives FAILSAFE=1 and a 150000 pulse.
//     One strobe restores a 200000 pulse and FAILSAFE=0 at the next boundary.

Source files
------------

// File: rtl/mc_signal_generator.sv
// rtl/mc_signal_generator.sv - RC-style pulse-frame generator for the motor-controller command path.
// Define MC_FAILSAFE_EN to build the CODE_VALID watchdog that forces neutral after missed refreshes.
module mc_signal_generator #(
    parameter int FRAME_CYCLES    = 1100000,
    parameter int NEUTRAL_CYCLES  = 150000,
    parameter int STEP_CYCLES     = 6250,
    parameter int FAILSAFE_FRAMES = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] MC_CODE,
    input  logic       CODE_VALID,
    output logic       MC_PWM,
    output logic [4:0] CURRENT_MC,
    output logic       FRAME_START,
    output logic       FAILSAFE
);

    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] NEUTRAL_W = CW'(NEUTRAL_CYCLES);
    localparam logic [CW-1:0] STEP_W    = CW'(STEP_CYCLES);
    localparam logic [4:0]    NEUTRAL_CODE = 5'b00001;

    typedef enum logic {
        GAP   = 1'b0,
        PULSE = 1'b1
    } state_t;

    // Forward and reverse pass through; neutral and the invalid dir both collapse to neutral.
    function automatic logic [4:0] canon(input logic [4:0] code);
        if (code[1:0] == 2'b10 || code[1:0] == 2'b00) begin
            return code;
        end
        return NEUTRAL_CODE;
    endfunction

    function automatic logic [CW-1:0] width_of(input logic [4:0] code);
        logic [CW-1:0] delta;
        delta = (CW'(code[4:2]) + CW'(1)) * STEP_W;
        case (code[1:0])
            2'b10:   return NEUTRAL_W + delta;
            2'b00:   return NEUTRAL_W - delta;
            default: return NEUTRAL_W;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] width_q, width_d;
    logic [4:0]    cur_q, cur_d;
    logic          run_q, run_d;
    logic          pwm_q, pwm_d;
    logic          fstart_q, fstart_d;
    logic          boundary;
    logic          force_neutral;

`ifdef MC_FAILSAFE_EN
    localparam int MW = $clog2(FAILSAFE_FRAMES + 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(FAILSAFE_FRAMES);

    logic [MW-1:0] miss_q, miss_d;
    logic [MW-1:0] miss_upd;
    logic          seen_q, seen_d;
    logic          seen_eff;
    logic          fs_q, fs_d;

    // A strobe on the boundary edge itself credits the frame that is closing.
    always_comb begin
        seen_eff = seen_q | CODE_VALID;
        miss_upd = miss_q;
        if (seen_eff) begin
            miss_upd = '0;
        end else if (miss_q != MISS_MAX) begin
            miss_upd = miss_q + MW'(1);
        end
        force_neutral = (miss_upd >= MISS_MAX);
        seen_d = boundary ? 1'b0 : seen_eff;
        miss_d = boundary ? miss_upd : miss_q;
        fs_d   = boundary ? force_neutral : fs_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            miss_q <= '0;
            seen_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            miss_q <= miss_d;
            seen_q <= seen_d;
            fs_q   <= fs_d;
        end
    end

    assign FAILSAFE = fs_q;
`else
    logic unused_code_valid;

    assign unused_code_valid = CODE_VALID;
    assign force_neutral     = 1'b0;
    assign FAILSAFE          = 1'b0;
`endif

    // run_q low means reset has just released: the next edge opens the first frame with cnt held at 0.
    assign boundary = !run_q || (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d    = cnt_q + CW'(1);
        run_d    = run_q;
        state_d  = state_q;
        cur_d    = cur_q;
        width_d  = width_q;
        fstart_d = 1'b0;
        if (boundary) begin
            cnt_d    = '0;
            run_d    = 1'b1;
            fstart_d = 1'b1;
            state_d  = PULSE;
            if (force_neutral) begin
                cur_d   = NEUTRAL_CODE;
                width_d = NEUTRAL_W;
            end else begin
                cur_d   = canon(MC_CODE);
                width_d = width_of(MC_CODE);
            end
        end else if (state_q == PULSE && cnt_q == width_q - CW'(1)) begin
            state_d = GAP;
        end
        pwm_d = (state_d == PULSE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= GAP;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            pwm_q    <= 1'b0;
            cur_q    <= NEUTRAL_CODE;
            width_q  <= NEUTRAL_W;
            fstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            pwm_q    <= pwm_d;
            cur_q    <= cur_d;
            width_q  <= width_d;
            fstart_q <= fstart_d;
        end
    end

    assign MC_PWM      = pwm_q;
    assign CURRENT_MC  = cur_q;
    assign FRAME_START = fstart_q;

endmodule
